// File: rtl/serdes_rx_fifo.sv
// Serial frame receiver: deserialises start/data/stop frames (LSB first)
// and queues completed words in a FIFO presented on a valid/ready output.
module serdes_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic                          serial_valid,
    output logic [DATA_WIDTH-1:0]         parallel_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;

    logic stop_strobe, push_req, bad_stop, pop, do_push;

    assign stop_strobe = (state == STOP) && serial_valid;
    assign push_req    = stop_strobe && serial_in;
    assign bad_stop    = stop_strobe && !serial_in;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The FSM only advances on strobed cycles; gaps freeze it in place.
    always_comb begin
        state_nx = state;
        if (serial_valid) begin
            case (state)
                IDLE:    if (!serial_in) state_nx = DATA;
                DATA:    if (bit_cnt == CW'(DATA_WIDTH - 1)) state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (serial_valid) begin
            case (state)
                IDLE: if (!serial_in) bit_cnt <= '0;
                DATA: begin
                    shift[bit_cnt] <= serial_in;
                    bit_cnt        <= bit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // A push into a full FIFO is only allowed when the head is leaving in the same cycle.
    assign pop     = valid_out && ready_in;
    assign do_push = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            frame_error <= bad_stop;
            overflow    <= push_req && fifo_full && !pop;
        end
    end

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign fifo_count   = wr_ptr - rd_ptr;
    assign valid_out    = !fifo_empty;
    // Storage is not reset, so the head is masked to zero while nothing is queued.
    assign parallel_out = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/serdes_rx_fifo.md
Name: serdes_rx_fifo

Overview:
- Receive-side counterpart of the team's serialiser/FIFO path.
- Samples a framed serial bit stream, deserialises each frame into a DATA_WIDTH word and buffers words in a FIFO.
- Presents buffered words on a valid/ready parallel output.
- Sits at the far end of the serial link, feeding parallel consumers.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- FIFO_DEPTH, 16, word entries in the receive FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial line, sampled only when serial_valid=1. Idles at 1.
- serial_valid  input  1  bit strobe; one line bit is consumed per cycle in which it is high.
- parallel_out  output  DATA_WIDTH  FIFO head word.
- valid_out  output  1  parallel_out holds a word; equals !fifo_empty.
- ready_in  input  1  consumer accepts; a pop occurs when valid_out && ready_in.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- fifo_empty  output  1  FIFO holds 0 words.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held.
- frame_error  output  1  one-cycle pulse when a bad stop bit is seen.
- overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Behaviour:
- Frame format: start bit 0, then DATA_WIDTH data bits LSB first, then stop bit 1.
- Bits count only on cycles with serial_valid=1. Gaps of any length between strobes are legal and freeze the FSM.

Reset (rst=1 at an edge):
- FSM goes to IDLE; bit counter and shift register are cleared.
- FIFO pointers are cleared.
- Outputs: fifo_empty=1, fifo_full=0, fifo_count=0, valid_out=0, frame_error=0, overflow=0, parallel_out=0.
- A partial frame in flight is discarded.
- Reset overrides all concurrent push/pop.

FSM:
- IDLE:
  - Strobed 0 -> DATA; bit_cnt=0.
  - Strobed 1 is line idle; stay in IDLE.
- DATA:
  - Each strobed bit is written to shift[bit_cnt]; bit_cnt increments.
  - The strobe that captures bit DATA_WIDTH-1 moves to STOP.
- STOP, on a strobe:
  - Bit 1: push the assembled word; go to IDLE.
  - Bit 0: drop the word, pulse frame_error for the next cycle, go to IDLE. Do not resynchronise on this 0; the next strobed 0 in IDLE starts a new frame.
- Back-to-back frames: a start bit on the strobe immediately after the stop bit is accepted. No idle bit is required.

FIFO:
- Push is at the STOP-accept edge. The word is visible on parallel_out with valid_out=1 in the following cycle when the FIFO was empty. Latency from stop-bit edge to valid_out is 1 cycle.
- No bypass path; the output is registered from FIFO storage.
- parallel_out is stable while valid_out=1 && ready_in=0.
- Pop while empty is ignored.
- Push while full with no simultaneous pop: the word is dropped, the FIFO is unchanged, and overflow pulses for 1 cycle.
- Push while full with a simultaneous pop: both occur, count stays FIFO_DEPTH, and there is no overflow.
- Push and pop in the same cycle at any other fill level: count unchanged.
- Pointers are $clog2(FIFO_DEPTH)+1 bits with MSB wrap. full is when the indexes are equal and the MSBs differ; empty is when the pointers are equal.
- frame_error and overflow never assert in the same cycle, because only one frame completes per cycle.

Test Plan:
- Reset, then frame 0xA5 (strobes 0,1,0,1,0,0,1,0,1,1) with ready_in=0:
  - valid_out=1 and parallel_out=0xA5 one cycle after the stop strobe.
  - fifo_count=1, fifo_empty=0.
- Same frame with serial_valid toggling 1-0-0-1 between bits -> identical result of 0xA5; the FSM holds during gaps.
- Frame 0x3C with stop bit 0:
  - frame_error pulses exactly 1 cycle.
  - FIFO stays empty.
  - A following good frame 0x11 is received correctly.
- 16 back-to-back frames 0x00..0x0F, then a 17th frame 0xFF, all with ready_in=0:
  - fifo_full=1 and fifo_count=16.
  - overflow pulses once; 0xFF is discarded.
  - Draining yields 0x00..0x0F in order, then fifo_empty=1.
- FIFO full, 17th stop bit 0x55 arrives in the same cycle as a pop with ready_in=1:
  - No overflow, count stays 16.
  - 0x55 appears as the last word drained.
- rst=1 after the 4th data bit of frame 0x77 with 2 words queued:
  - Next cycle fifo_empty=1, fifo_count=0, valid_out=0.
  - A subsequent frame 0x77 is received intact.
